// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store initiator between the core memory stage and data_mem.
// Memory accesses are word aligned; byte/half stores use a read-modify-write pass.
module data_mem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam logic [DATA_WIDTH-1:0] BYTE_MASK = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
    localparam logic [DATA_WIDTH-1:0] HALF_MASK = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_STORE,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_size;
    logic [1:0]              r_off;
    logic                    r_unsigned;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [ADDR_WIDTH-1:0]   r_addr;

    logic                    w_accept;
    logic                    w_req_err;
    logic [4:0]              w_shamt;
    logic [DATA_WIDTH-1:0]   w_rd_shift;
    logic [DATA_WIDTH-1:0]   w_load_ext;
    logic [DATA_WIDTH-1:0]   w_lane_mask;
    logic [DATA_WIDTH-1:0]   w_merged;

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign resp_err    = resp_valid && r_err;
    assign resp_rdata  = r_rdata;
    assign mem_wr_sel  = (r_state == S_STORE);
    assign mem_wr_data = mem_wr_sel ? r_wdata : '0;
    assign mem_addr    = r_addr;

    assign w_accept  = req_valid && req_ready;
    assign w_req_err = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)               w_next = S_RESP;
                    else if (!req_wr)            w_next = S_LOAD;
                    else if (req_size == 2'b10)  w_next = S_STORE;
                    else                         w_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_RMW_RD: w_next = S_STORE;
            S_STORE:  w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Lane k lives at bits [8k+7:8k]; shifting by offset*8 brings it to lane 0.
    assign w_shamt    = {r_off, 3'b000};
    assign w_rd_shift = mem_rd_data >> w_shamt;

    always_comb begin
        w_load_ext = w_rd_shift;
        case (r_size)
            2'b00:   w_load_ext = {{(DATA_WIDTH-8){~r_unsigned & w_rd_shift[7]}}, w_rd_shift[7:0]};
            2'b01:   w_load_ext = {{(DATA_WIDTH-16){~r_unsigned & w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_load_ext = w_rd_shift;
        endcase
    end

    assign w_lane_mask = ((r_size == 2'b00) ? BYTE_MASK : HALF_MASK) << w_shamt;
    assign w_merged    = (mem_rd_data & ~w_lane_mask) | ((r_wdata << w_shamt) & w_lane_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size     <= '0;
            r_off      <= '0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_addr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size     <= req_size;
                        r_off      <= req_addr[1:0];
                        r_unsigned <= req_unsigned;
                        r_err      <= w_req_err;
                        r_wdata    <= req_wdata;
                        r_rdata    <= '0;
                        // Errors never touch memory, so mem_addr keeps the last real access.
                        if (!w_req_err) begin
                            r_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                S_LOAD:   r_rdata <= w_load_ext;
                S_RMW_RD: r_wdata <= w_merged;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed and random requests against a
// word-array memory model and an arithmetic reference of the load/store rules.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    int n_chk = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_acc = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:15];

    data_mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_wr_sel(mem_wr_sel), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wr_sel) mem[mem_addr[9:2]] <= mem_wr_data;
    end

    always @(negedge clk) begin
        if (mem_wr_sel) begin
            n_wr++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wr_data;
        end
        if (req_valid && req_ready) n_acc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] size,
                                             input bit uns, input int unsigned off);
        int unsigned v;
        case (size)
            2'd0: begin
                v = (w >> (8 * off)) % 256;
                if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (w >> (16 * (off / 2))) % 65536;
                if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_store(input logic [31:0] w, input logic [1:0] size,
                                              input int unsigned off, input logic [31:0] wd);
        int unsigned sh, unit, old_lane;
        if (size == 2'd2) return wd;
        unit = (size == 2'd0) ? 256 : 65536;
        sh   = (size == 2'd0) ? 8 * off : 16 * (off / 2);
        old_lane = (w >> sh) % unit;
        return w - (old_lane << sh) + ((wd % unit) << sh);
    endfunction

    task automatic do_req(input bit wr, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
        bit          err;
        int unsigned off, widx, lat, exp_lat;
        int          wr0, acc0;
        logic [31:0] old_w, new_w, exp_rd;
        off   = addr % 4;
        widx  = addr / 4;
        err   = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
        old_w = ref_mem[widx];
        new_w = old_w;
        exp_rd = '0;
        if (!err && !wr) exp_rd = exp_load(old_w, size, uns, off);
        if (!err && wr)  new_w  = exp_store(old_w, size, off, wdata);
        exp_lat = err ? 1 : (!wr ? 2 : (size == 2'd2 ? 2 : 3));

        chk("ready_idle", 32'(req_ready), 32'd1);
        wr0  = n_wr;
        acc0 = n_acc;
        req_wr = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            chk("ready_busy", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("latency", lat, exp_lat);
        chk("resp_err", 32'(resp_err), 32'(err));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("ready_resp", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("accept_once", n_acc - acc0, 32'd1);
        chk("wr_pulses", n_wr - wr0, (wr && !err) ? 32'd1 : 32'd0);
        if (wr && !err) begin
            chk("wr_addr", last_wr_addr, addr & 32'hFFFF_FFFC);
            chk("wr_data", last_wr_data, new_w);
            ref_mem[widx] = new_w;
        end
        chk("mem_word", mem[widx], ref_mem[widx]);
    endtask

    initial begin
        int wr_before;
        for (int unsigned i = 0; i < 16; i++) ref_mem[i] = '0;

        #2;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_wr_sel", 32'(mem_wr_sel), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wr_data", mem_wr_data, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int unsigned i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, i * 4, $urandom, 1'b0);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB, 1'b0);
        chk("merge_literal", mem[4], 32'h11AB_3344);

        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0);

        do_req(1'b1, 2'd2, 1'b0, 32'h13, 32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 32'h08, 32'h1234_5678, 1'b0);

        // Back-to-back loads with req_valid never dropping.
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1);
        do_req(1'b0, 2'd0, 1'b0, 32'h24, 32'h0, 1'b0);

        // Reset asserted during the read half of a byte store.
        wr_before = n_wr;
        req_wr = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr_sel", 32'(mem_wr_sel), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_err", 32'(resp_err), 32'd0);
        chk("midrst_rdata", resp_rdata, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_wr_data", mem_wr_data, 32'd0);
        @(posedge clk); #1;
        chk("midrst_no_write", n_wr - wr_before, 32'd0);
        chk("midrst_mem", mem[4], ref_mem[4]);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int unsigned i = 0; i < 40; i++) begin
            do_req(1'($urandom % 2), 2'($urandom_range(0, 3)), 1'($urandom % 2),
                   32'($urandom_range(0, 63)), $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store initiator that sits between the core's memory stage and data_mem, and drives data_mem's wr_sel/addr/wr_data/rd_data interface.
- Accepts byte, halfword and word loads/stores from the core over a valid/ready handshake.
- Performs word-aligned data_mem accesses, with read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data, and flags misaligned accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, byte address width on both core and memory sides.
- DATA_WIDTH, 32, data word width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  unit can accept a request this cycle.
- req_wr  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  1 = zero-extend load data, 0 = sign-extend.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal-size access; qualified by resp_valid.
- mem_wr_sel  output  1  data_mem write enable.
- mem_addr  output  ADDR_WIDTH  word-aligned address, low 2 bits always 00.
- mem_wr_data  output  DATA_WIDTH  data_mem write data.
- mem_rd_data  input  DATA_WIDTH  data_mem read data; combinational from mem_addr.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_err, mem_wr_sel = 0.
  - resp_rdata, mem_addr, mem_wr_data = 0.
  - Latched request registers are cleared.
- Reset mid-operation:
  - Abandons the access.
  - mem_wr_sel drops at once, so no write occurs at the next edge.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready=1 only in IDLE; the core holds request fields until accepted.
  - Request fields are latched at acceptance and ignored afterwards.
- Error check at acceptance:
  - An error is a half access with addr[0]=1, a word access with addr[1:0]!=00, or req_size=11.
  - An error request goes to RESP with resp_err=1 and makes no memory access.
- States and transitions:
  - IDLE: waits for acceptance. Error request -> RESP; load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
  - LOAD: mem_addr = latched addr with [1:0]=00, mem_wr_sel=0. At the edge, select the byte/half at offset addr[1:0], extend it per req_unsigned, and register it into resp_rdata. -> RESP.
  - RMW_RD: mem_wr_sel=0. At the edge, capture mem_rd_data and merge the store bytes into lane addr[1:0] (byte: 1 lane; half: lanes addr[1]*2 and +1). -> STORE.
  - STORE: mem_wr_sel=1, mem_wr_data = merged word (word store: req_wdata unchanged). data_mem writes on this edge. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle; resp_rdata and resp_err are valid. -> IDLE.
- mem_addr holds the last access address in IDLE and RESP; mem_wr_sel=0 in every state except STORE.
- Latency (resp_valid high N cycles after the acceptance edge):
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- Throughput: the next request can be accepted on the edge that ends RESP+1, i.e. in the first IDLE cycle. There is no overlap between requests.
- Byte order: little-endian. Lane k is data bits [8k+7:8k].

Test Plan:
- Word store req_addr=0x10, req_wdata=0xDEADBEEF, then word load 0x10 -> mem_wr_sel high exactly one cycle with mem_addr=0x10; load resp_rdata=0xDEADBEEF, resp_err=0, latency 2.
- Memory word 0x10=0x11223344; byte store addr=0x12, wdata=0xAB -> RMW_RD then STORE; mem_wr_data=0x11AB3344; latency 3.
- Memory 0x20=0x80FF7F01: signed byte load 0x22 -> 0xFFFFFFFF; unsigned byte 0x23 -> 0x00000080; signed half 0x20 -> 0x00007F01; signed half 0x22 -> 0xFFFF80FF.
- Misaligned word store at 0x13 and half load at 0x21 -> resp_err=1 after 1 cycle, resp_rdata=0, mem_wr_sel never asserted, memory unchanged.
- req_valid held high continuously across three loads -> req_ready low in LOAD and RESP; each request is accepted exactly once; resp_valid is a single-cycle pulse per request.
- Assert rst_n low during the RMW_RD cycle of a byte store to 0x10 -> mem_wr_sel stays 0, word 0x10 unchanged, outputs return to reset values with no clock edge needed, req_ready=1.
